// File: rtl/oport_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// oport_fifo: first-word-fall-through byte FIFO between the core's OPORT stores and an
// off-chip valid/ready consumer; bytes arriving while full and not draining are dropped into OVF.
module oport_fifo #(
   parameter int DATA_LEN = 8,
   parameter int DEPTH    = 4,
   parameter int ADDR_LEN = 2
) (
   input  logic                CLK,
   input  logic                RSTN,
   input  logic                WR_EN,
   input  logic [DATA_LEN-1:0] WR_DATA,
   output logic [DATA_LEN-1:0] OUT_DATA,
   output logic                OUT_VALID,
   input  logic                OUT_READY,
   output logic                FULL,
   output logic [ADDR_LEN:0]   COUNT,
   output logic                OVF,
   input  logic                OVF_CLR
);

   localparam logic [ADDR_LEN:0]   c_depth   = (ADDR_LEN+1)'(DEPTH);
   localparam logic [ADDR_LEN:0]   c_cnt_one = (ADDR_LEN+1)'(1);
   localparam logic [ADDR_LEN-1:0] c_ptr_one = ADDR_LEN'(1);

   logic [DATA_LEN-1:0] mem_q [DEPTH];
   logic [ADDR_LEN-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_LEN-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_LEN:0]   count_q, count_d;
   logic                ovf_q, ovf_d;
   logic                w_push, w_pop;

   assign OUT_VALID = (count_q != '0);
   assign FULL      = (count_q == c_depth);
   assign COUNT     = count_q;
   assign OVF       = ovf_q;
   assign OUT_DATA  = OUT_VALID ? mem_q[rd_ptr_q] : '0;

   // A full FIFO still accepts a write when the head is leaving on the same edge.
   assign w_pop  = OUT_VALID & OUT_READY;
   assign w_push = WR_EN & (~FULL | w_pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + c_ptr_one;
      end
      if (w_push) begin
         wr_ptr_d = wr_ptr_q + c_ptr_one;
      end
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + c_cnt_one;
         2'b01:   count_d = count_q - c_cnt_one;
         default: count_d = count_q;
      endcase
      // A drop in the same cycle as a clear must still be reported.
      if (WR_EN & ~w_push) begin
         ovf_d = 1'b1;
      end else if (OVF_CLR) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= WR_DATA;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_oport_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// tb_oport_fifo: directed scenarios plus a randomized run against a queue-based reference model.
module tb_oport_fifo;

   localparam int DEPTH = 4;

   logic       CLK = 1'b0;
   logic       RSTN = 1'b0;
   logic       WR_EN = 1'b0;
   logic [7:0] WR_DATA = '0;
   logic       OUT_READY = 1'b0;
   logic       OVF_CLR = 1'b0;
   logic [7:0] OUT_DATA;
   logic       OUT_VALID;
   logic       FULL;
   logic [2:0] COUNT;
   logic       OVF;

   int checks = 0;
   int errors = 0;

   logic [7:0] q[$];
   logic       m_ovf = 1'b0;

   always #5 CLK = ~CLK;

   oport_fifo #(.DATA_LEN(8), .DEPTH(4), .ADDR_LEN(2)) dut (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .WR_EN     (WR_EN),
      .WR_DATA   (WR_DATA),
      .OUT_DATA  (OUT_DATA),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .FULL      (FULL),
      .COUNT     (COUNT),
      .OVF       (OVF),
      .OVF_CLR   (OVF_CLR)
   );

   // {valid, full, ovf, count, data}
   function automatic logic [13:0] model_vec();
      logic v;
      v = (q.size() != 0);
      return {v, (q.size() == DEPTH), m_ovf, 3'(q.size()), v ? q[0] : 8'h00};
   endfunction

   function automatic logic [13:0] dut_vec();
      return {OUT_VALID, FULL, OVF, COUNT, OUT_DATA};
   endfunction

   // One clock: drive inputs, advance the model on the edge, return at the next negedge.
   task automatic cycle(input logic wr, input logic [7:0] d, input logic rdy, input logic clr);
      bit pop, push;
      WR_EN = wr; WR_DATA = d; OUT_READY = rdy; OVF_CLR = clr;
      @(posedge CLK);
      pop  = (q.size() != 0) && rdy;
      push = wr && ((q.size() < DEPTH) || pop);
      if (wr && !push) m_ovf = 1'b1;
      else if (clr)    m_ovf = 1'b0;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(d);
      @(negedge CLK);
      WR_EN = 1'b0; OUT_READY = 1'b0; OVF_CLR = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (dut_vec() !== 14'h0) begin
         errors++; $display("FAIL reset_state got %h exp %h", dut_vec(), 14'h0);
      end
      @(negedge CLK);
      RSTN = 1'b1;
   endtask

   task automatic test_single();
      cycle(1'b1, 8'h11, 1'b0, 1'b0);
      checks++;
      if ({OUT_VALID, OUT_DATA, COUNT} !== {1'b1, 8'h11, 3'd1}) begin
         errors++; $display("FAIL single_push got %b/%h/%0d exp 1/11/1", OUT_VALID, OUT_DATA, COUNT);
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if ({OUT_VALID, OUT_DATA, COUNT} !== {1'b0, 8'h00, 3'd0}) begin
         errors++; $display("FAIL single_pop got %b/%h/%0d exp 0/00/0", OUT_VALID, OUT_DATA, COUNT);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
      checks++;
      if ({FULL, COUNT, OVF} !== {1'b1, 3'd4, 1'b0}) begin
         errors++; $display("FAIL fill got full=%b count=%0d ovf=%b exp 1/4/0", FULL, COUNT, OVF);
      end
      cycle(1'b1, 8'hA5, 1'b0, 1'b0);
      checks++;
      if ({OVF, COUNT, OUT_DATA} !== {1'b1, 3'd4, 8'hA1}) begin
         errors++; $display("FAIL drop got ovf=%b count=%0d head=%h exp 1/4/a1", OVF, COUNT, OUT_DATA);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({OUT_VALID, OUT_DATA} !== {1'b1, 8'hA1 + 8'(i)}) begin
            errors++; $display("FAIL drain%0d got %b/%h exp 1/%h", i, OUT_VALID, OUT_DATA, 8'hA1 + 8'(i));
         end
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
      end
      checks++;
      if ({OUT_VALID, COUNT, OUT_DATA} !== {1'b0, 3'd0, 8'h00}) begin
         errors++; $display("FAIL drain_empty got %b/%0d/%h exp 0/0/00", OUT_VALID, COUNT, OUT_DATA);
      end
   endtask

   task automatic test_full_pushpop();
      logic [7:0] exp_seq [4];
      exp_seq[0] = 8'hA2; exp_seq[1] = 8'hA3; exp_seq[2] = 8'hA4; exp_seq[3] = 8'hB5;
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
      cycle(1'b1, 8'hB5, 1'b1, 1'b0);
      checks++;
      if ({FULL, COUNT, OVF, OUT_DATA} !== {1'b1, 3'd4, 1'b1, 8'hA2}) begin
         errors++; $display("FAIL full_pushpop got full=%b count=%0d ovf=%b head=%h exp 1/4/1/a2",
                            FULL, COUNT, OVF, OUT_DATA);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({OUT_VALID, OUT_DATA} !== {1'b1, exp_seq[i]}) begin
            errors++; $display("FAIL full_drain%0d got %b/%h exp 1/%h", i, OUT_VALID, OUT_DATA, exp_seq[i]);
         end
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 8'(i), 1'b1, 1'b0);
         checks++;
         if ({OUT_VALID, OUT_DATA, COUNT} !== {1'b1, 8'(i), 3'd1}) begin
            errors++; $display("FAIL wrap%0d got %b/%h/%0d exp 1/%h/1", i, OUT_VALID, OUT_DATA, COUNT, 8'(i));
         end
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if ({OUT_VALID, COUNT} !== {1'b0, 3'd0}) begin
         errors++; $display("FAIL wrap_end got %b/%0d exp 0/0", OUT_VALID, COUNT);
      end
   endtask

   task automatic test_ovf_priority();
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
      cycle(1'b1, 8'hC5, 1'b0, 1'b1);
      checks++;
      if ({OVF, COUNT} !== {1'b1, 3'd4}) begin
         errors++; $display("FAIL ovf_set_wins got ovf=%b count=%0d exp 1/4", OVF, COUNT);
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      checks++;
      if ({OVF, COUNT} !== {1'b0, 3'd4}) begin
         errors++; $display("FAIL ovf_clear got ovf=%b count=%0d exp 0/4", OVF, COUNT);
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0);
      cycle(1'b1, 8'h3F, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if ({COUNT, OVF} !== {3'd3, 1'b0}) begin
         errors++; $display("FAIL pre_reset got count=%0d ovf=%b exp 3/0", COUNT, OVF);
      end
      cycle(1'b1, 8'h40, 1'b0, 1'b0);
      cycle(1'b1, 8'h41, 1'b0, 1'b0);
      #2 RSTN = 1'b0;
      #1;
      checks++;
      if (dut_vec() !== 14'h0) begin
         errors++; $display("FAIL async_reset got %h exp %h", dut_vec(), 14'h0);
      end
      q.delete();
      m_ovf = 1'b0;
      #1 RSTN = 1'b1;
      @(negedge CLK);
      cycle(1'b1, 8'h5A, 1'b0, 1'b0);
      checks++;
      if ({OUT_VALID, OUT_DATA, COUNT} !== {1'b1, 8'h5A, 3'd1}) begin
         errors++; $display("FAIL post_reset got %b/%h/%0d exp 1/5a/1", OUT_VALID, OUT_DATA, COUNT);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         cycle($urandom_range(0, 9) < 7, 8'($urandom), 1'($urandom_range(0, 1)),
               $urandom_range(0, 15) == 0);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL random%0d got %h exp %h", n, dut_vec(), model_vec());
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_full_pushpop();
      test_wrap();
      test_ovf_priority();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/oport_fifo.md
Name: oport_fifo

Overview:
- Output-port buffer directly downstream of the accumulator datapath.
- Captures each byte the core stores to register 0 (OPORT) and queues it in a small FIFO.
- Presents the queued bytes to off-chip logic over a valid/ready handshake, so a slow consumer does not miss back-to-back port writes.
- Flags dropped bytes with a sticky overflow bit.

Parameters:
- DATA_LEN, 8, width of each buffered byte; matches core data width.
- DEPTH, 4, number of FIFO entries; must be a power of two, 2 or greater.
- ADDR_LEN, 2, log2(DEPTH); pointer width.

Ports:
- CLK  input  1  single clock; all state updates on posedge.
- RSTN  input  1  asynchronous active-low reset; clears all state immediately, released synchronously by the integrator.
- WR_EN  input  1  push strobe; driven by the core as IS_ST & (REG_ID == 0).
- WR_DATA  input  DATA_LEN  byte to push; the accumulator value being stored, sampled on the same edge as WR_EN.
- OUT_DATA  output  DATA_LEN  head-of-FIFO byte; meaningful only while OUT_VALID=1.
- OUT_VALID  output  1  FIFO non-empty.
- OUT_READY  input  1  consumer accepts OUT_DATA this cycle.
- FULL  output  1  COUNT == DEPTH.
- COUNT  output  ADDR_LEN+1  current number of entries, 0..DEPTH.
- OVF  output  1  sticky overflow flag.
- OVF_CLR  input  1  synchronous clear of OVF.

Behaviour:
- Reset (RSTN=0, asynchronous): rd_ptr=0, wr_ptr=0, COUNT=0, OVF=0, OUT_VALID=0, FULL=0, OUT_DATA=0. Storage contents need not be cleared.
- pop = OUT_VALID & OUT_READY.
- push = WR_EN & (~FULL | pop).
- Both are evaluated on the same posedge.
- Push: mem[wr_ptr] <= WR_DATA; wr_ptr increments modulo DEPTH (natural ADDR_LEN-bit wrap).
- Pop: rd_ptr increments modulo DEPTH.
- COUNT update: +1 on push only, -1 on pop only, unchanged on both or neither.
- First-word-fall-through: OUT_DATA = mem[rd_ptr] combinationally while OUT_VALID=1; OUT_DATA = 0 while empty.
- Latency: a byte pushed at edge N is visible with OUT_VALID=1 after edge N. There is no same-cycle bypass from WR_DATA to OUT_DATA.
- Handshake: OUT_DATA and OUT_VALID hold stable until popped. The consumer may hold OUT_READY high continuously; the FIFO then drains one byte per cycle.
- OUT_READY while empty is ignored; no pointer change.
- Full with WR_EN=1 and pop=1: push accepted; COUNT stays DEPTH; no overflow.
- Full with WR_EN=1 and pop=0: byte dropped; pointers and COUNT unchanged; OVF <= 1.
- Empty with WR_EN=1 and OUT_READY=1: push only, since pop needs OUT_VALID. COUNT becomes 1.
- OVF priority: a drop event and OVF_CLR in the same cycle leave OVF=1 (set wins). OVF_CLR alone sets OVF <= 0.
- Reset asserted mid-operation discards all queued bytes. OUT_VALID falls immediately, without waiting for a clock edge.
- FULL and OUT_VALID are decoded from COUNT: no separate registers and no glitch-free requirement beyond synchronous logic.
- Core is never stalled. Back-pressure is handled only by dropping and flagging.

Test Plan:
1. Reset, then push 0x11 with OUT_READY=0 -> after that edge: OUT_VALID=1, OUT_DATA=0x11, COUNT=1. Raise OUT_READY for one cycle -> OUT_VALID=0, OUT_DATA=0, COUNT=0.
2. Push 0xA1,0xA2,0xA3,0xA4 on consecutive cycles with OUT_READY=0 -> FULL=1, COUNT=4. Push 0xA5 -> dropped, OVF=1. Drain -> exactly 0xA1..0xA4 in order.
3. FIFO full, assert WR_EN=1 (0xB5) and OUT_READY=1 in the same cycle -> 0xA1 popped, 0xB5 accepted, COUNT stays 4, OVF unchanged.
4. Pointer wrap: 10 push/pop pairs of 0x00..0x09 with OUT_READY=1 held -> consumer receives 0x00..0x09 in order, one per cycle after first latency. COUNT never exceeds 1.
5. OVF=1, drive an overflow push and OVF_CLR=1 in the same cycle -> OVF stays 1. Next cycle OVF_CLR=1 alone -> OVF=0.
6. Three entries queued, pulse RSTN low between edges -> OUT_VALID=0, COUNT=0, OVF=0 immediately. After release, push 0x5A -> OUT_DATA=0x5A.
